bcd_serial_add_ctrl: RTL and testbench

BCD_SERIAL_ADD_CTRL -- requirements
Module: bcd_serial_add_ctrl

---
 rtl/bcd_serial_add_ctrl_pkg.sv | 25 ++
 rtl/bcd_serial_add_ctrl_sevenseg_dec.sv | 26 ++
 rtl/bcd_serial_add_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Shared types and constants for the serial BCD adder and its seven-segment display.
package bcd_serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned BCD_MAX = 9;

    // Active-low segments, bit order a..g from MSB to LSB
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_serial_add_ctrl_sevenseg_dec.sv
// Seven-segment decoder for one BCD digit; values above 9 show blank.
module sevenseg_dec
    import bcd_serial_add_ctrl_pkg::*;
(
    input  logic [3:0] digit,
    output logic [0:6] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder (one digit per cycle) with seven-segment display outputs.
// HEX0..HEX8 cover the largest NDIG; displays above HEX<NDIG> are held blank.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits on the display only.
module bcd_serial_add_ctrl
    import bcd_serial_add_ctrl_pkg::*;
#(
    parameter int unsigned NDIG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*NDIG-1:0] a,
    input  logic [4*NDIG-1:0] b,
    input  logic              cin,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] sum,
    output logic              cout,
    output logic              err,
    output logic [0:6]        HEX0,
    output logic [0:6]        HEX1,
    output logic [0:6]        HEX2,
    output logic [0:6]        HEX3,
    output logic [0:6]        HEX4,
    output logic [0:6]        HEX5,
    output logic [0:6]        HEX6,
    output logic [0:6]        HEX7,
    output logic [0:6]        HEX8
);

    localparam int unsigned W     = 4 * NDIG;
    localparam int unsigned IW    = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned NHEX  = 9;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic            c_q, c_d;
    logic            busy_d, done_d, cout_d, err_d;
    logic [W-1:0]    sum_d;

    logic [3:0]      da, db, ds;
    logic [4:0]      t;
    logic            bad, cn;

    // Shared digit adder working on the digit selected by idx_q
    always_comb begin
        da  = a_q[{idx_q, 2'b00} +: 4];
        db  = b_q[{idx_q, 2'b00} +: 4];
        t   = 5'(da) + 5'(db) + 5'(c_q);
        bad = (da > 4'(BCD_MAX)) || (db > 4'(BCD_MAX));
        ds  = t[3:0];
        cn  = 1'b0;
        if (bad) begin
            ds = 4'hF;
        end else if (t > 5'(BCD_MAX)) begin
            ds = 4'(t - 5'd10);
            cn = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        acc_d   = acc_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        sum_d   = sum;
        cout_d  = cout;
        err_d   = err;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = cin;
                    idx_d   = '0;
                    acc_d   = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ADD;
                end
            end
            ADD: begin
                acc_d[{idx_q, 2'b00} +: 4] = ds;
                c_d    = cn;
                busy_d = 1'b1;
                if (bad) err_d = 1'b1;
                if (idx_q == IW'(NDIG - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sum_d   = acc_d;
                    cout_d  = cn;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            acc_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            busy    <= busy_d;
            done    <= done_d;
            sum     <= sum_d;
            cout    <= cout_d;
            err     <= err_d;
        end
    end

    // Display digit values; 4'hF decodes to blank
    logic [3:0] disp [0:NDIG];

`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    always_comb begin
        lead       = ~cout;
        disp[NDIG] = cout ? 4'd1 : 4'hF;
        for (int k = NDIG - 1; k >= 0; k--) begin
            disp[k] = sum[4*k +: 4];
            if ((k != 0) && lead && (sum[4*k +: 4] == 4'd0)) disp[k] = 4'hF;
            if (sum[4*k +: 4] != 4'd0) lead = 1'b0;
        end
    end
`else
    always_comb begin
        disp[NDIG] = {3'b000, cout};
        for (int k = 0; k < NDIG; k++) begin
            disp[k] = sum[4*k +: 4];
        end
    end
`endif

    logic [0:6] seg [0:NHEX-1];

    for (genvar g = 0; g < NHEX; g++) begin : g_hex
        if (g <= NDIG) begin : g_dec
            sevenseg_dec u_dec (
                .digit (disp[g]),
                .seg   (seg[g])
            );
        end else begin : g_off
            assign seg[g] = SEG_BLANK;
        end
    end

    assign HEX0 = seg[0];
    assign HEX1 = seg[1];
    assign HEX2 = seg[2];
    assign HEX3 = seg[3];
    assign HEX4 = seg[4];
    assign HEX5 = seg[5];
    assign HEX6 = seg[6];
    assign HEX7 = seg[7];
    assign HEX8 = seg[8];

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl (NDIG=4): vector table, corner sequences, random vs model.
module tb_bcd_serial_add_ctrl;

    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;

    logic          clk = 1'b0;
    logic          rst, start, cin;
    logic [W-1:0]  a, b;
    logic          busy, done, cout, err;
    logic [W-1:0]  sum;
    logic [0:6]    hx [0:8];

    int total = 0;
    int bad   = 0;

    bcd_serial_add_ctrl #(.NDIG(NDIG)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err),
        .HEX0(hx[0]), .HEX1(hx[1]), .HEX2(hx[2]), .HEX3(hx[3]), .HEX4(hx[4]),
        .HEX5(hx[5]), .HEX6(hx[6]), .HEX7(hx[7]), .HEX8(hx[8])
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    // Reference: decimal digit-by-digit addition with the invalid-digit rule
    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                         output logic [W-1:0] s, output logic co, output logic er);
        int carry = int'(ci);
        s  = '0;
        er = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            int xd = int'(x[4*k +: 4]);
            int yd = int'(y[4*k +: 4]);
            if (xd > 9 || yd > 9) begin
                er = 1'b1;
                s[4*k +: 4] = 4'hF;
                carry = 0;
            end else begin
                int v = xd + yd + carry;
                s[4*k +: 4] = 4'(v % 10);
                carry = v / 10;
            end
        end
        co = (carry != 0);
    endtask

    task automatic chk_hex(input string name, input logic [W-1:0] s, input logic co);
        logic [6:0] exp_seg, act;
        logic       lead;
        lead = 1'b1;
        for (int k = 8; k >= 0; k--) begin
            if (k > NDIG) exp_seg = 7'b1111111;
            else if (k == NDIG) exp_seg = seg_of({3'b000, co});
            else exp_seg = seg_of(s[4*k +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
            if (k == NDIG && !co) exp_seg = 7'b1111111;
            if (k < NDIG) begin
                if (co) lead = 1'b0;
                if (k > 0 && lead && s[4*k +: 4] == 4'd0) exp_seg = 7'b1111111;
                if (s[4*k +: 4] != 4'd0) lead = 1'b0;
            end
`endif
            act = hx[k];
            chk($sformatf("%s HEX%0d", name, k), 32'(act), 32'(exp_seg));
        end
    endtask

    // Pulse start with operands, scramble inputs, and wait (bounded) for done
    task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                          input string name, output int n, output int bcnt);
        logic [W-1:0] prev;
        prev  = sum;
        a     = x;
        b     = y;
        cin   = ci;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
        n     = 1;
        bcnt  = 0;
        while (!done && n < 30) begin
            if (busy) bcnt++;
            if (n == 2) chk({name, " sum hold"}, 32'(sum), 32'(prev));
            tick();
            n++;
        end
    endtask

    vec_t vecs [8];

    initial begin
        int n, bcnt, seen;
        logic [W-1:0] es;
        logic eco, eer;

        vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
        vecs[1] = '{16'h9999, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h12A4, 16'h0001, 1'b0, 16'h12F5, 1'b0, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[4] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
        vecs[5] = '{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{16'h0FFF, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b1};
        vecs[7] = '{16'h4321, 16'h1234, 1'b1, 16'h5556, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick();
        tick();
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset sum", 32'(sum), 0);
        chk("reset cout", 32'(cout), 0);
        chk("reset err", 32'(err), 0);
        chk_hex("reset", '0, 1'b0);
        rst = 1'b0;
        tick();

        // Table vectors
        foreach (vecs[i]) begin
            string nm = $sformatf("vec%0d", i);
            do_add(vecs[i].a, vecs[i].b, vecs[i].cin, nm, n, bcnt);
            chk({nm, " latency"}, 32'(n), NDIG + 1);
            chk({nm, " busy cycles"}, 32'(bcnt), NDIG);
            chk({nm, " done"}, 32'(done), 1);
            chk({nm, " busy at done"}, 32'(busy), 0);
            chk({nm, " sum"}, 32'(sum), 32'(vecs[i].sum));
            chk({nm, " cout"}, 32'(cout), 32'(vecs[i].cout));
            chk({nm, " err"}, 32'(err), 32'(vecs[i].err));
            chk_hex(nm, vecs[i].sum, vecs[i].cout);
            tick();
            chk({nm, " done pulse"}, 32'(done), 0);
            chk({nm, " err held"}, 32'(err), 32'(vecs[i].err));
        end

        // start re-pulsed during ADD is ignored
        a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        tick();
        a = 16'h7777; b = 16'h1111; cin = 1'b1; start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 3;
        while (!done && n < 30) begin tick(); n++; end
        chk("repulse latency", 32'(n), NDIG + 1);
        chk("repulse sum", 32'(sum), 32'h6912);
        chk("repulse cout", 32'(cout), 0);
        tick();
        chk("repulse no restart", 32'(busy), 0);

        // rst in the 3rd ADD cycle aborts with no done
        a = 16'h9999; b = 16'h0001; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort busy", 32'(busy), 0);
        chk("abort done", 32'(done), 0);
        chk("abort sum", 32'(sum), 0);
        chk("abort cout", 32'(cout), 0);
        chk("abort err", 32'(err), 0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (done || busy) seen++;
            tick();
        end
        chk("abort stays idle", 32'(seen), 0);

        // rst wins over start in the same cycle
        a = 16'h1111; b = 16'h2222; rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rst priority busy", 32'(busy), 0);
        tick();
        chk("rst priority idle", 32'(busy), 0);

        // Random operands, back-to-back starts issued in the DONE cycle
        for (int r = 0; r < 40; r++) begin
            logic [W-1:0] x, y;
            logic ci;
            string nm = $sformatf("rnd%0d", r);
            for (int k = 0; k < NDIG; k++) begin
                x[4*k +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                y[4*k +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            end
            ci = 1'($urandom);
            model(x, y, ci, es, eco, eer);
            do_add(x, y, ci, nm, n, bcnt);
            chk({nm, " latency"}, 32'(n), NDIG + 1);
            chk({nm, " sum"}, 32'(sum), 32'(es));
            chk({nm, " cout"}, 32'(cout), 32'(eco));
            chk({nm, " err"}, 32'(err), 32'(eer));
            if (r % 8 == 0) chk_hex(nm, es, eco);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
